// File: rtl/uart_pkg.sv
// uart_pkg: line levels, parity selectors and FSM encoding
// shared by the UART transmitter and receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;

   // x is the XOR-reduction of the payload.
   function automatic logic par_bit(input logic x, input logic typ);
      return x ^ (typ == PAR_ODD);
   endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// tx_bit_timer: bit-period edge counter plus payload bit index.
// done_o pulses in the last cycle of each bit period.
module tx_bit_timer #(
   parameter int DATA_WIDTH = 8,
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          run_i,
   input  logic          bit_inc_i,
   input  logic [5:0]    presc_i,
   output logic          done_o,
   output logic [BW-1:0] bit_idx_o
);
   import uart_pkg::*;

   logic [5:0]    edge_q, edge_d;
   logic [BW-1:0] bit_q, bit_d;

   assign done_o    = run_i && (edge_q == presc_i - 6'd1);
   assign bit_idx_o = bit_q;

   always_comb begin
      edge_d = edge_q;
      bit_d  = bit_q;
      if (clr_i) begin
         edge_d = '0;
         bit_d  = '0;
      end else if (!run_i) begin
         edge_d = '0;
      end else if (done_o) begin
         edge_d = '0;
         if (bit_inc_i) begin
            bit_d = (bit_q == BW'(DATA_WIDTH - 1)) ? '0 : bit_q + BW'(1);
         end
      end else begin
         edge_d = edge_q + 6'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         edge_q <= '0;
         bit_q  <= '0;
      end else begin
         edge_q <= edge_d;
         bit_q  <= bit_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: registered-output UART transmitter, optional parity.
// Define UART_TX_B2B_EN to chain frames with no idle gap.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [5:0]            Prescale,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   uart_state_e           state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic [5:0]            presc_q, presc_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  accept;
   logic                  done;
   logic [BW-1:0]         bit_idx;
   logic [BW-1:0]         nxt_idx;

`ifdef UART_TX_B2B_EN
   assign accept = Data_Valid &&
                   (state_q == IDLE || (state_q == STOP && done));
`else
   assign accept = Data_Valid && (state_q == IDLE);
`endif

   tx_bit_timer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_timer (
      .clk_i    (CLK),
      .rst_i    (RST),
      .clr_i    (accept),
      .run_i    (state_q != IDLE),
      .bit_inc_i(state_q == DATA),
      .presc_i  (presc_q),
      .done_o   (done),
      .bit_idx_o(bit_idx)
   );

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      presc_d   = presc_q;
      nxt_idx   = bit_idx;
      unique case (state_q)
         IDLE: ;
         START: if (done) state_d = DATA;
         DATA: begin
            if (done) begin
               if (bit_idx == BW'(DATA_WIDTH - 1)) begin
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  nxt_idx = bit_idx + BW'(1);
               end
            end
         end
         PARITY: if (done) state_d = STOP;
         STOP: if (done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (accept) begin
         state_d   = START;
         data_d    = P_DATA;
         par_en_d  = PAR_EN;
         par_typ_d = PAR_TYP;
         presc_d   = (Prescale == 6'd0) ? 6'd1 : Prescale;
      end
      // Line level is decided from the next state so TX_OUT is a flop.
      busy_d = (state_d != IDLE);
      unique case (state_d)
         IDLE:    tx_d = IDLE_LVL;
         START:   tx_d = START_BIT;
         DATA:    tx_d = data_q[nxt_idx];
         PARITY:  tx_d = par_bit(^data_q, par_typ_q);
         STOP:    tx_d = STOP_BIT;
         default: tx_d = IDLE_LVL;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         presc_q   <= '0;
         tx_q      <= IDLE_LVL;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         presc_q   <= presc_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign TX_OUT = tx_q;
   assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: vector table plus frame scoreboard for uart_tx.
// Hand sequences cover mid-frame requests, reset abort, back-to-back.
module tb_uart_tx;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [5:0] Prescale;
   logic       TX_OUT;
   logic       Busy;

   always #5 CLK = ~CLK;

   uart_tx #(.DATA_WIDTH(8)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .P_DATA    (P_DATA),
      .Data_Valid(Data_Valid),
      .PAR_EN    (PAR_EN),
      .PAR_TYP   (PAR_TYP),
      .Prescale  (Prescale),
      .TX_OUT    (TX_OUT),
      .Busy      (Busy)
   );

   typedef struct {
      logic [767:0] w;
      int           len;
   } exp_t;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       pt;
      logic [5:0] p;
      logic       pbit;
      int         len;
   } vec_t;

   exp_t         sb[$];
   vec_t         vt[7];
   int           tests = 0;
   int           fails = 0;
   logic         mon_en;
   logic [767:0] cap;
   int           n = 0;
   int           last_len = 0;

   function automatic void put_bit(inout exp_t e, input logic b, input int pp);
      for (int k = 0; k < pp; k++) begin
         e.w[e.len] = b;
         e.len++;
      end
   endfunction

   function automatic void add_frame(inout exp_t e, input logic [7:0] d,
                                     input logic pe, input logic pbit,
                                     input int p);
      int pp;
      pp = (p == 0) ? 1 : p;
      put_bit(e, 1'b0, pp);
      for (int i = 0; i < 8; i++) put_bit(e, d[i], pp);
      if (pe) put_bit(e, pbit, pp);
      put_bit(e, 1'b1, pp);
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Frame monitor: captures TX_OUT while Busy, compares on Busy fall.
   always @(negedge CLK) begin
      if (RST || !mon_en) begin
         n   = 0;
         cap = '0;
      end else if (Busy) begin
         if (n < 768) cap[n] = TX_OUT;
         n++;
      end else if (n > 0) begin
         last_len = n;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL frame_unexpected: got len %0d expected none", n);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (n != e.len || cap != e.w) begin
               fails++;
               $display("FAIL frame_wave: got len %0d wave %h expected len %0d wave %h",
                        n, cap[255:0], e.len, e.w[255:0]);
            end
         end
         n   = 0;
         cap = '0;
      end
   end

   task automatic send(input vec_t v, input bit push);
      exp_t e;
      if (push) begin
         e.w   = '0;
         e.len = 0;
         add_frame(e, v.d, v.pe, v.pbit, int'(v.p));
         sb.push_back(e);
      end
      P_DATA     = v.d;
      PAR_EN     = v.pe;
      PAR_TYP    = v.pt;
      Prescale   = v.p;
      Data_Valid = 1'b1;
      @(posedge CLK);
      #1;
      Data_Valid = 1'b0;
      P_DATA     = 8'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      Prescale   = 6'($urandom);
      @(negedge CLK);
      chk("latency_busy", int'(Busy), 1);
      chk("latency_start", int'(TX_OUT), 0);
   endtask

   task automatic wait_idle(input int limit);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < limit; k++) begin
         @(negedge CLK);
         #1;
         if (!Busy && sb.size() == 0 && n == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL timeout: got busy %0d pending %0d expected idle", Busy, sb.size());
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t  v;
      exp_t  e;
      logic  bz[200];
      int    first;
      int    last;
      int    gap;

      vt[0] = '{8'hA5, 1'b0, 1'b0, 6'd8,  1'b0, 80};
      vt[1] = '{8'h03, 1'b1, 1'b0, 6'd16, 1'b0, 176};
      vt[2] = '{8'h03, 1'b1, 1'b1, 6'd16, 1'b1, 176};
      vt[3] = '{8'hFF, 1'b0, 1'b0, 6'd0,  1'b0, 10};
      vt[4] = '{8'hFF, 1'b0, 1'b0, 6'd1,  1'b0, 10};
      vt[5] = '{8'h5A, 1'b1, 1'b1, 6'd4,  1'b1, 44};
      vt[6] = '{8'h3C, 1'b1, 1'b0, 6'd3,  1'b0, 33};

      RST        = 1'b1;
      Data_Valid = 1'b0;
      P_DATA     = '0;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      Prescale   = '0;
      mon_en     = 1'b1;
      repeat (3) @(negedge CLK);
      chk("reset_tx", int'(TX_OUT), 1);
      chk("reset_busy", int'(Busy), 0);
      RST = 1'b0;

      for (int i = 0; i < 7; i++) begin
         @(posedge CLK);
         #1;
         chk("idle_line", int'(TX_OUT), 1);
         send(vt[i], 1'b1);
         wait_idle(2000);
         chk("frame_len", last_len, vt[i].len);
      end

      // Request during DATA of a 0x5A frame must be dropped.
      v = '{8'h5A, 1'b0, 1'b0, 6'd4, 1'b0, 40};
      @(posedge CLK);
      #1;
      send(v, 1'b1);
      repeat (8) @(posedge CLK);
      #1;
      P_DATA     = 8'h11;
      Data_Valid = 1'b1;
      @(posedge CLK);
      #1;
      Data_Valid = 1'b0;
      wait_idle(2000);
      chk("mid_len", last_len, 40);
      repeat (6) @(negedge CLK);
      chk("no_ghost", int'(Busy), 0);

      // Reset in cycle 3 of data bit 4, then a fresh 0x3C frame.
      mon_en = 1'b0;
      v = '{8'h96, 1'b0, 1'b0, 6'd8, 1'b0, 80};
      @(posedge CLK);
      #1;
      send(v, 1'b0);
      repeat (42) @(negedge CLK);
      chk("abort_midframe", int'(Busy), 1);
      #1;
      RST = 1'b1;
      #1;
      chk("abort_tx", int'(TX_OUT), 1);
      chk("abort_busy", int'(Busy), 0);
      @(posedge CLK);
      #2;
      chk("abort_hold_busy", int'(Busy), 0);
      @(negedge CLK);
      RST    = 1'b0;
      mon_en = 1'b1;
      v = '{8'h3C, 1'b0, 1'b0, 6'd8, 1'b0, 80};
      send(v, 1'b1);
      wait_idle(2000);
      chk("post_reset_len", last_len, 80);

      // Data_Valid held high across two frames.
      e.w   = '0;
      e.len = 0;
      add_frame(e, 8'h81, 1'b0, 1'b0, 8);
`ifdef UART_TX_B2B_EN
      add_frame(e, 8'h7E, 1'b0, 1'b0, 8);
      sb.push_back(e);
`else
      sb.push_back(e);
      e.w   = '0;
      e.len = 0;
      add_frame(e, 8'h7E, 1'b0, 1'b0, 8);
      sb.push_back(e);
`endif
      @(posedge CLK);
      #1;
      P_DATA     = 8'h81;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      Prescale   = 6'd8;
      Data_Valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(posedge CLK);
         #1;
         if (i == 0) P_DATA = 8'h7E;
         if (i == 81) Data_Valid = 1'b0;
         @(negedge CLK);
         bz[i] = Busy;
      end
      first = -1;
      last  = -1;
      for (int i = 0; i < 200; i++) begin
         if (bz[i]) begin
            if (first < 0) first = i;
            last = i;
         end
      end
      gap = 0;
      for (int i = 0; i < 200; i++) begin
         if (first >= 0 && i > first && i < last && !bz[i]) gap++;
      end
      chk("b2b_first", first, 0);
`ifdef UART_TX_B2B_EN
      chk("b2b_gap", gap, 0);
      chk("b2b_span", last - first + 1, 160);
`else
      chk("b2b_gap_min", int'(gap >= 1), 1);
      chk("b2b_span", last - first + 1, 160 + gap);
`endif
      wait_idle(2000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
